mode_timer_core: RTL and testbench

Sequential core of the two-mode timer, directly downstream of the 25-bit 2-way period mux. It consumes the mux's selected 25-bit prescale period and divides the system clock into one-second ticks. It runs a minutes:seconds counter either up (stopwatch) or down (countdown). Its outputs feed the display/decoder stage.

---
 rtl/mode_timer_core_pkg.sv | 36 +++
 rtl/mode_timer_core_tick_prescaler.sv | 50 +++++
 rtl/mode_timer_core.sv | 154 +++++++++++++++
 tb/tb_mode_timer_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mode_timer_core_pkg.sv
// Shared definitions for the two-mode minutes:seconds timer core.
// State encoding, time limits, count-direction constants and preset clamp helper.
package mode_timer_core_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [5:0] MAX_SEC = 6'd59;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef struct packed {
    logic [6:0] min;
    logic [5:0] sec;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = '{min: 7'd0, sec: 6'd0};

  // Saturate an out-of-range countdown preset to the largest displayable time.
  function automatic mmss_t clamp_preset(input logic [6:0] pmin,
                                         input logic [5:0] psec,
                                         input logic [6:0] max_min);
    mmss_t r;
    r.min = (pmin > max_min) ? max_min : pmin;
    r.sec = (psec > MAX_SEC) ? MAX_SEC : psec;
    return r;
  endfunction

  function automatic logic is_zero(input mmss_t t);
    return (t.min == 7'd0) && (t.sec == 6'd0);
  endfunction

endpackage

// File: rtl/mode_timer_core_tick_prescaler.sv
// Divides clk by the selected period; tick is combinational so the time
// counter can update on the same edge the prescaler wraps.
module mode_timer_core_tick_prescaler
  import mode_timer_core_pkg::*;
#(
  parameter int PERIOD_W = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                en,
  input  logic                clr,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ZERO_P = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] ONE_P  = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] last_s;

  // Last count value before wrap; period 0 behaves like period 1. The >= in the
  // tick compare lets a shrinking period fire immediately instead of wrapping.
  always_comb begin
    if (period == ZERO_P) begin
      last_s = ZERO_P;
    end else begin
      last_s = period - ONE_P;
    end
    tick = en && (cnt_r >= last_s);
  end

  // Prescale counter: cleared on request, advances only while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= ZERO_P;
    end else if (clr) begin
      cnt_r <= ZERO_P;
    end else if (en) begin
      if (tick) begin
        cnt_r <= ZERO_P;
      end else begin
        cnt_r <= cnt_r + ONE_P;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mode_timer_core.sv
// Two-mode (stopwatch / countdown) minutes:seconds timer core: control FSM,
// min:sec counter and the one-second prescaler instance.
module mode_timer_core
  import mode_timer_core_pkg::*;
#(
  parameter int PERIOD_W = 25,
  parameter int MAX_MIN  = 99
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                mode,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [6:0]          preset_min,
  input  logic [5:0]          preset_sec,
  output logic [6:0]          minutes,
  output logic [5:0]          seconds,
  output logic                tick,
  output logic                running,
  output logic                expired
);

  localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  mmss_t      time_r;
  mmss_t      time_nxt_s;
  logic       mode_q_r;
  logic       mode_nxt_s;
  logic       tick_r;
  logic       running_r;
  logic       expired_r;
  logic       ps_en_s;
  logic       ps_clr_s;
  logic       ps_tick_s;

  // Prescaler counts only in an undisturbed RUN cycle and sits at zero in IDLE.
  assign ps_en_s  = (state_r == ST_RUN) && !clear && !stop;
  assign ps_clr_s = clear || (state_r == ST_IDLE);

  mode_timer_core_tick_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .period (period),
    .en     (ps_en_s),
    .clr    (ps_clr_s),
    .tick   (ps_tick_s)
  );

  // Next-state, next-time and direction latch; clear outranks stop outranks start.
  always_comb begin
    state_nxt_s = state_r;
    time_nxt_s  = time_r;
    mode_nxt_s  = mode_q_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
      if (mode == MODE_DOWN) begin
        time_nxt_s = clamp_preset(preset_min, preset_sec, MAX_MIN_L);
      end else begin
        time_nxt_s = MMSS_ZERO;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_nxt_s = mode;
            if ((mode == MODE_DOWN) && is_zero(time_r)) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_nxt_s = ST_PAUSE;
          end else if (!ps_tick_s) begin
            state_nxt_s = ST_RUN;
          end else if (mode_q_r == MODE_UP) begin
            if ((time_r.min == MAX_MIN_L) && (time_r.sec == MAX_SEC)) begin
              state_nxt_s = ST_DONE;
            end else if (time_r.sec == MAX_SEC) begin
              time_nxt_s.sec = 6'd0;
              time_nxt_s.min = time_r.min + 7'd1;
            end else begin
              time_nxt_s.sec = time_r.sec + 6'd1;
            end
          end else begin
            // Countdown finishes on the edge that lands on 00:00.
            if (is_zero(time_r)) begin
              state_nxt_s = ST_DONE;
            end else if (time_r.sec == 6'd0) begin
              time_nxt_s.sec = MAX_SEC;
              time_nxt_s.min = time_r.min - 7'd1;
            end else begin
              time_nxt_s.sec = time_r.sec - 6'd1;
              if ((time_r.min == 7'd0) && (time_r.sec == 6'd1)) begin
                state_nxt_s = ST_DONE;
              end else begin
                state_nxt_s = ST_RUN;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, time and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      time_r    <= MMSS_ZERO;
      mode_q_r  <= MODE_UP;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      time_r    <= time_nxt_s;
      mode_q_r  <= mode_nxt_s;
      tick_r    <= ps_tick_s;
      running_r <= (state_nxt_s == ST_RUN);
      expired_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign minutes = time_r.min;
  assign seconds = time_r.sec;
  assign tick    = tick_r;
  assign running = running_r;
  assign expired = expired_r;

endmodule

// File: tb/tb_mode_timer_core.sv
// Self-checking bench for mode_timer_core: directed scenarios plus randomized
// stimulus compared every cycle against a total-seconds reference model.
module tb_mode_timer_core;

  localparam int MAX_T = 99 * 60 + 59;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_PAUSE = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] period;
  logic        mode, start, stop, clear;
  logic [6:0]  preset_min;
  logic [5:0]  preset_sec;
  logic [6:0]  minutes;
  logic [5:0]  seconds;
  logic        tick, running, expired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time held as total elapsed/remaining seconds.
  int m_phase, m_total, m_cnt;
  bit m_down, m_tick;

  always #5 clk = ~clk;

  mode_timer_core dut (
    .clk(clk), .rst_n(rst_n), .period(period), .mode(mode),
    .start(start), .stop(stop), .clear(clear),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .minutes(minutes), .seconds(seconds), .tick(tick),
    .running(running), .expired(expired)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit s, input bit st);
    int eff, pm, ps;
    m_tick = 1'b0;
    if (!r) begin
      m_phase = PH_IDLE; m_total = 0; m_down = 1'b0; m_cnt = 0;
    end else if (c) begin
      m_phase = PH_IDLE;
      m_cnt = 0;
      pm = (int'(preset_min) > 99) ? 99 : int'(preset_min);
      ps = (int'(preset_sec) > 59) ? 59 : int'(preset_sec);
      m_total = mode ? pm * 60 + ps : 0;
    end else if (m_phase == PH_IDLE) begin
      if (st) begin
        m_down = mode;
        m_phase = (mode && m_total == 0) ? PH_DONE : PH_RUN;
      end
    end else if (m_phase == PH_RUN) begin
      if (s) begin
        m_phase = PH_PAUSE;
      end else begin
        eff = (period == 25'd0) ? 1 : int'(period);
        if (m_cnt + 1 >= eff) begin
          m_tick = 1'b1;
          m_cnt = 0;
          if (!m_down) begin
            if (m_total == MAX_T) m_phase = PH_DONE;
            else m_total++;
          end else begin
            m_total--;
            if (m_total == 0) m_phase = PH_DONE;
          end
        end else begin
          m_cnt++;
        end
      end
    end else if (m_phase == PH_PAUSE) begin
      if (st) m_phase = PH_RUN;
    end
  endtask

  task automatic compare_all();
    check_val("minutes", minutes, m_total / 60);
    check_val("seconds", seconds, m_total % 60);
    check_val("tick",    tick,    m_tick);
    check_val("running", running, m_phase == PH_RUN);
    check_val("expired", expired, m_phase == PH_DONE);
  endtask

  // One clock: drive at negedge, advance model, check at following negedge.
  task automatic cyc(input bit r, input bit c, input bit s, input bit st);
    rst_n = r; clear = c; stop = s; start = st;
    model_step(r, c, s, st);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_i, last_i, n;
    bit got;
    rst_n = 1'b0; period = 25'd4; mode = 1'b0; start = 1'b0; stop = 1'b0;
    clear = 1'b0; preset_min = 7'd0; preset_sec = 6'd0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_running", running, 32'd0);

    // Up count, period 4; reset mid-run at 00:03.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_sec", seconds, 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_sec", seconds, 32'd0);
    check_val("rst_run", running, 32'd0);
    check_val("rst_tick", tick, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    first_i = -1; last_i = -1;
    for (int i = 0; i < 240; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (tick) begin
        if (first_i < 0) first_i = i;
        if (last_i >= 0) check_val("tick_gap", i - last_i, 32'd4);
        last_i = i;
      end
    end
    check_val("first_tick_lat", first_i + 1, 32'd4);
    check_val("up_1min_min", minutes, 32'd1);
    check_val("up_1min_sec", seconds, 32'd0);

    // Countdown 00:02, period 3.
    mode = 1'b1; period = 25'd3; preset_min = 7'd0; preset_sec = 6'd2;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("cd_load", seconds, 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("cd_1", seconds, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("cd_0", seconds, 32'd0);
    check_val("cd_expired", expired, 32'd1);
    check_val("cd_running", running, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("cd_start_ignored", expired, 32'd1);

    // Pause / resume, period 10.
    mode = 1'b0; period = 25'd10;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("pause_tick", tick, 32'd0);
    end
    check_val("pause_sec", seconds, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
      got = tick;
    end
    check_val("resume_lat", n, 32'd4);

    // period 0 ticks every cycle.
    period = 25'd0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("p0_tick", tick, 32'd1);
    end

    // Clamped preset, then count up from 99:59 to saturation.
    mode = 1'b1; preset_min = 7'd120; preset_sec = 6'd63; period = 25'd1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("clamp_min", minutes, 32'd99);
    check_val("clamp_sec", seconds, 32'd59);
    mode = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("sat_min", minutes, 32'd99);
    check_val("sat_sec", seconds, 32'd59);
    check_val("sat_expired", expired, 32'd1);

    // Countdown from 00:00 goes straight to DONE without a tick.
    mode = 1'b1; preset_min = 7'd0; preset_sec = 6'd0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("zero_expired", expired, 32'd1);
    check_val("zero_tick", tick, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("zero_tick2", tick, 32'd0);

    // Priority checks.
    mode = 1'b0; period = 25'd5;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    mode = 1'b1; preset_min = 7'd3; preset_sec = 6'd4;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("prio_clr_run", running, 32'd0);
    check_val("prio_clr_min", minutes, 32'd3);
    check_val("prio_clr_sec", seconds, 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check_val("prio_stop_run", running, 32'd0);
    check_val("prio_stop_exp", expired, 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) period = 25'($urandom_range(0, 12));
      mode = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        preset_min = 7'($urandom_range(0, 127));
        preset_sec = 6'($urandom_range(0, 63));
      end else begin
        preset_min = 7'($urandom_range(0, 1));
        preset_sec = 6'($urandom_range(0, 5));
      end
      cyc($urandom_range(0, 999) != 0, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
